// File: rtl/video_pkg.sv
// Shared VGA timing defaults and the total-period derivation used by scanout and drawing logic.
package video_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    function automatic int timing_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/fb_scanout_if.sv
// Framebuffer read port: address out, synchronous read data back one clk later.
interface fb_scanout_if #(
    parameter int AW    = 17,
    parameter int DATAW = 1
);
    logic [AW-1:0]    addr_read;
    logic [DATAW-1:0] data_out;

    modport master (output addr_read, input  data_out);
    modport slave  (input  addr_read, output data_out);
endinterface

// File: rtl/vga_timing.sv
// Raster counters plus raw (undelayed) hsync/vsync/de; also exposes the next counter state.
module vga_timing
    import video_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter int HW       = 10,
    parameter int VW       = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_ce,
    output logic [HW-1:0] hcnt,
    output logic [VW-1:0] vcnt,
    output logic [HW-1:0] hcnt_nxt,
    output logic [VW-1:0] vcnt_nxt,
    output logic          hs_raw,
    output logic          vs_raw,
    output logic          de_raw
);
    localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

    always_comb begin
        hcnt_nxt = (hcnt == H_LAST) ? '0 : hcnt + HW'(1);
        vcnt_nxt = vcnt;
        if (hcnt == H_LAST)
            vcnt_nxt = (vcnt == V_LAST) ? '0 : vcnt + VW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (pix_ce) begin
            hcnt <= hcnt_nxt;
            vcnt <= vcnt_nxt;
        end
    end

    assign de_raw = (hcnt < H_ACT) && (vcnt < V_ACT);
    assign hs_raw = !((hcnt >= HS_BEG) && (hcnt <= HS_END));
    assign vs_raw = !((vcnt >= VS_BEG) && (vcnt <= VS_END));

endmodule

// File: rtl/fb_scanout.sv
// 2x-upscaled framebuffer scanout with one-tick aligned video outputs.
// Optional checkerboard test pattern: define FB_SCANOUT_TESTPAT_EN to add the test_sel input.
module fb_scanout
    import video_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter int FB_W     = 320,
    parameter int FB_H     = 240,
    parameter int DATAW    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_ce,
`ifdef FB_SCANOUT_TESTPAT_EN
    input  logic             test_sel,
`endif
    fb_scanout_if.master     fb,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [DATAW-1:0] pix,
    output logic             frame_start
);
    localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int AW      = $clog2(FB_W * FB_H);

    localparam logic [HW-1:0] H_ACT = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_ACT = VW'(V_ACTIVE);

    logic [HW-1:0] hcnt, hcnt_nxt;
    logic [VW-1:0] vcnt, vcnt_nxt;
    logic          hs_raw, vs_raw, de_raw;

    vga_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HW(HW), .VW(VW)
    ) u_timing (
        .clk(clk), .rst(rst), .pix_ce(pix_ce),
        .hcnt(hcnt), .vcnt(vcnt), .hcnt_nxt(hcnt_nxt), .vcnt_nxt(vcnt_nxt),
        .hs_raw(hs_raw), .vs_raw(vs_raw), .de_raw(de_raw)
    );

    // Address tracks the post-tick raster position, so the RAM samples it during
    // the whole tick and its data is ready when that position is output.
    logic [AW-1:0] row_base, base_nxt, addr_q;
    logic          vis_nxt;

    always_comb begin
        base_nxt = row_base;
        if (hcnt_nxt == '0) begin
            if (vcnt_nxt == '0)
                base_nxt = '0;
            else if (!vcnt_nxt[0] && (vcnt_nxt < V_ACT))
                base_nxt = row_base + AW'(FB_W);
        end
    end

    assign vis_nxt = (hcnt_nxt < H_ACT) && (vcnt_nxt < V_ACT);

    always_ff @(posedge clk) begin
        if (rst) begin
            row_base <= '0;
            addr_q   <= '0;
        end else if (pix_ce) begin
            row_base <= base_nxt;
            if (vis_nxt)
                addr_q <= base_nxt + AW'(hcnt_nxt >> 1);
        end
    end

    assign fb.addr_read = addr_q;

    logic             pend;
    logic [DATAW-1:0] pix_live, pix_hold;

`ifdef FB_SCANOUT_TESTPAT_EN
    logic tp_q;
    assign pix_live = !de ? '0 : (test_sel ? {DATAW{tp_q}} : fb.data_out);
`else
    assign pix_live = de ? fb.data_out : '0;
`endif

    // RAM data is live only in the clk right after a tick; latch it so pix stays
    // steady through pix_ce gaps while the RAM re-reads the next address.
    always_ff @(posedge clk) begin
        if (rst) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            de          <= 1'b0;
            frame_start <= 1'b0;
            pend        <= 1'b0;
            pix_hold    <= '0;
`ifdef FB_SCANOUT_TESTPAT_EN
            tp_q        <= 1'b0;
`endif
        end else begin
            frame_start <= pix_ce && de_raw && (hcnt == '0) && (vcnt == '0);
            pend        <= pix_ce;
            if (pend)
                pix_hold <= pix_live;
            if (pix_ce) begin
                hsync <= hs_raw;
                vsync <= vs_raw;
                de    <= de_raw;
`ifdef FB_SCANOUT_TESTPAT_EN
                tp_q  <= hcnt[4] ^ vcnt[4];
`endif
            end
        end
    end

    assign pix = pend ? pix_live : pix_hold;

endmodule

// File: tb/tb_fb_scanout.sv
// Directed bench for fb_scanout on a reduced raster (40x28 total, 16x12 framebuffer).
module tb_fb_scanout;
    localparam int HA = 32, HFP = 2, HSW = 4, HBP = 2;
    localparam int VA = 24, VFP = 1, VSW = 2, VBP = 1;
    localparam int FBW = 16, FBH = 12;
    localparam int HT = HA + HFP + HSW + HBP;   // 40
    localparam int VT = VA + VFP + VSW + VBP;   // 28
    localparam int FRAME = HT * VT;             // 1120
    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pix_ce = 1'b0;
    logic hsync, vsync, de, frame_start;
    logic [0:0] pix;
`ifdef FB_SCANOUT_TESTPAT_EN
    logic test_sel = 1'b0;
`endif

    fb_scanout_if #(.AW(AW), .DATAW(1)) fbif ();

    fb_scanout #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .FB_W(FBW), .FB_H(FBH), .DATAW(1)
    ) dut (
        .clk(clk), .rst(rst), .pix_ce(pix_ce),
`ifdef FB_SCANOUT_TESTPAT_EN
        .test_sel(test_sel),
`endif
        .fb(fbif.master),
        .hsync(hsync), .vsync(vsync), .de(de), .pix(pix), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Synchronous framebuffer RAM whose contents are addr[0].
    always @(posedge clk) fbif.data_out <= fbif.addr_read[0];

    int tests = 0, fails = 0;
    int ch, cv, lva, tick;
    bit tsel = 1'b0;
    int de_cnt, fs_cnt, vs_low, hs_low0, hs_first, fs1, fs2, max_addr, l2_addr;
    int seq [8];
    int tp_a, tp_b;

    function automatic int fbaddr(input int h, input int v);
        return (v >> 1) * FBW + (h >> 1);
    endfunction

    task automatic chk(input string tag, input int obs, input int req);
        tests++;
        assert (obs === req) else begin
            fails++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, req);
        end
    endtask

    task automatic chk_vec(input logic e_de, input logic e_hs, input logic e_vs,
                           input logic e_pix, input logic e_fs, input int e_addr);
        logic [12:0] obs, req;
        obs = {de, hsync, vsync, pix, frame_start, fbif.addr_read};
        req = {e_de, e_hs, e_vs, e_pix, e_fs, 8'(e_addr)};
        tests++;
        assert (obs === req) else begin
            fails++;
            $error("FAIL tick%0d de/hs/vs/pix/fs/addr observed %b/%b/%b/%b/%b/%0d required %b/%b/%b/%b/%b/%0d",
                   tick, de, hsync, vsync, pix, frame_start, fbif.addr_read,
                   e_de, e_hs, e_vs, e_pix, e_fs, e_addr);
        end
    endtask

    task automatic model_reset();
        ch = 0; cv = 0; lva = 0; tick = 0;
        de_cnt = 0; fs_cnt = 0; vs_low = 0; hs_low0 = 0;
        hs_first = -1; fs1 = -1; fs2 = -1;
    endtask

    // One pixel tick followed by gap-1 idle clks; outputs reflect the pre-tick position.
    task automatic step(input int gap);
        int ph, pv;
        logic e_de, e_hs, e_vs, e_pix, e_fs;
        pix_ce = 1'b1;
        @(posedge clk); #1;
        pix_ce = 1'b0;
        tick++;
        ph = ch; pv = cv;
        if (ch == HT - 1) begin
            ch = 0;
            cv = (cv == VT - 1) ? 0 : cv + 1;
        end else ch++;
        if (ch < HA && cv < VA) lva = fbaddr(ch, cv);
        e_de = (ph < HA) && (pv < VA);
        e_hs = !((ph >= HA + HFP) && (ph < HA + HFP + HSW));
        e_vs = !((pv >= VA + VFP) && (pv < VA + VFP + VSW));
        if (tsel) e_pix = e_de && ((((ph >> 4) ^ (pv >> 4)) & 1) == 1);
        else      e_pix = e_de && ((fbaddr(ph, pv) & 1) == 1);
        e_fs = (ph == 0) && (pv == 0);
        chk_vec(e_de, e_hs, e_vs, e_pix, e_fs, lva);
        if (tick < 8) seq[tick] = int'(fbif.addr_read);
        if (ch == 0 && cv == 2 && l2_addr < 0) l2_addr = int'(fbif.addr_read);
        if (int'(fbif.addr_read) > max_addr) max_addr = int'(fbif.addr_read);
        if (ph == 16 && pv == 0)  tp_a = int'(pix);
        if (ph == 16 && pv == 16) tp_b = int'(pix);
        if (frame_start) begin
            if (fs1 < 0) fs1 = tick; else if (fs2 < 0) fs2 = tick;
        end
        if (tick <= FRAME) begin
            if (de) de_cnt++;
            if (frame_start) fs_cnt++;
            if (!vsync) vs_low++;
            if (pv == 0 && !hsync) begin
                hs_low0++;
                if (hs_first < 0) hs_first = tick;
            end
        end
        for (int i = 1; i < gap; i++) begin
            @(posedge clk); #1;
            chk_vec(e_de, e_hs, e_vs, e_pix, 1'b0, lva);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; pix_ce = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int seq_req [8] = '{0, 0, 1, 1, 2, 2, 3, 3};
        max_addr = 0; l2_addr = -1; tp_a = -1; tp_b = -1;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hsync", int'(hsync), 1);
        chk("rst_vsync", int'(vsync), 1);
        chk("rst_de", int'(de), 0);
        chk("rst_pix", int'(pix), 0);
        chk("rst_fs", int'(frame_start), 0);
        chk("rst_addr", int'(fbif.addr_read), 0);
        seq[0] = int'(fbif.addr_read);
        rst = 1'b0;

        // pix_ce every clk, one full frame plus a few ticks
        repeat (FRAME + 5) step(1);
        for (int i = 0; i < 8; i++) chk($sformatf("line0_addr%0d", i), seq[i], seq_req[i]);
        chk("line2_addr_start", l2_addr, FBW);
        chk("max_addr", max_addr, FBW * FBH - 1);
        chk("de_ticks", de_cnt, HA * VA);
        chk("fs_per_frame", fs_cnt, 1);
        chk("fs_first_tick", fs1, 1);
        chk("frame_ticks", fs2 - fs1, FRAME);
        chk("hs_low_ticks", hs_low0, HSW);
        chk("hs_low_first", hs_first, HA + HFP + 1);
        chk("vs_low_ticks", vs_low, VSW * HT);

        // pix_ce every 2nd clk: same sequence, each output held 2 clk
        do_reset();
        repeat (FRAME + 2) step(2);
        chk("ce2_de_ticks", de_cnt, HA * VA);
        chk("ce2_fs_per_frame", fs_cnt, 1);
        chk("ce2_vs_low_ticks", vs_low, VSW * HT);

        // Mid-frame reset at hcnt=20, vcnt=10, with pix_ce also high
        do_reset();
        repeat (10 * HT + 20) step(1);
        chk("pre_rst_pos", ch + cv * HT, 10 * HT + 20);
        rst = 1'b1; pix_ce = 1'b1;
        @(posedge clk); #1;
        chk("mrst_de", int'(de), 0);
        chk("mrst_hsync", int'(hsync), 1);
        chk("mrst_vsync", int'(vsync), 1);
        chk("mrst_addr", int'(fbif.addr_read), 0);
        chk("mrst_pix", int'(pix), 0);
        chk("mrst_fs", int'(frame_start), 0);
        rst = 1'b0; pix_ce = 1'b0;
        model_reset();
        @(posedge clk); #1;
        chk("mrst_idle_fs", int'(frame_start), 0);
        repeat (50) step(1);
        chk("mrst_fs_once", fs_cnt, 1);
        chk("mrst_fs_tick", fs1, 1);

`ifdef FB_SCANOUT_TESTPAT_EN
        // Checkerboard: fb_x[3]^fb_y[3]
        test_sel = 1'b1; tsel = 1'b1;
        do_reset();
        repeat (17 * HT) step(1);
        chk("tp_x8_y0", tp_a, 1);
        chk("tp_x8_y8", tp_b, 0);
        test_sel = 1'b0; tsel = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fb_scanout.md
FB_SCANOUT -- requirements
Module: fb_scanout

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP/H_SYNC/H_BP, defaults 16/96/48, horizontal porch and sync widths in pixels.
REQ-003 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 SHALL have parameters V_FP/V_SYNC/V_BP, defaults 10/2/33, vertical porch and sync widths in lines.
REQ-005 SHALL have parameters FB_W=320, FB_H=240, DATAW=1, matching the framebuffer geometry and pixel width.
REQ-006 SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-008 SHALL have port pix_ce, input, 1 bit, pixel-tick strobe; one screen pixel advances per clk with pix_ce=1.
REQ-009 SHALL have port addr_read, output, $clog2(FB_W*FB_H) bits, framebuffer read address.
REQ-010 SHALL have port data_out, input, DATAW bits, framebuffer read data, valid one clk after addr_read.
REQ-011 SHALL have ports hsync and vsync, output, 1 bit each, active-low sync.
REQ-012 SHALL have port de, output, 1 bit, high during visible pixels.
REQ-013 SHALL have port pix, output, DATAW bits, pixel value, forced to 0 when de=0.
REQ-014 SHALL have port frame_start, output, 1 bit, one-clk pulse at the first visible pixel tick of each frame.

Function
REQ-015 SHALL hold hcnt (0..H_TOTAL-1) and vcnt (0..V_TOTAL-1), where H_TOTAL=800 and V_TOTAL=525 by default, and advance them only on pix_ce.
REQ-016 SHALL wrap hcnt from H_TOTAL-1 to 0 and increment vcnt on that same tick; vcnt SHALL wrap from V_TOTAL-1 to 0.
REQ-017 SHALL map the visible region to the framebuffer by 2x upscaling: fb_x=hcnt>>1, fb_y=vcnt>>1.
REQ-018 SHALL compute addr_read with no multiplier, as a row-base register plus fb_x.
REQ-019 SHALL add FB_W to the row base once every two visible lines.
REQ-020 SHALL clear the row base at vcnt wrap.
REQ-021 SHALL hold addr_read at the last visible address outside the active region and SHALL never present an address >= FB_W*FB_H.
REQ-022 SHALL issue the address on the pixel tick before the data is consumed.
REQ-023 SHALL delay hsync/vsync/de by exactly one pixel tick, so that pix, de and the syncs are mutually aligned.
REQ-024 SHALL have a total pipeline latency of one pixel tick from counter state to outputs.
REQ-025 SHALL require the gap between pix_ce pulses to be >= 1 clk; back-to-back pix_ce (every clk) SHALL be supported.
REQ-026 SHALL assert hsync low for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], before the one-tick delay.
REQ-027 SHALL assert vsync low for vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], before the one-tick delay.
REQ-028 SHALL hold all outputs steady while pix_ce=0.

Reset
REQ-029 SHALL, on rst=1, clear hcnt, vcnt, the row base and addr_read to 0.
REQ-030 SHALL, on rst=1, drive hsync=1, vsync=1, de=0, pix=0 and frame_start=0 at the next edge.
REQ-031 SHALL give rst priority over pix_ce.
REQ-032 SHALL restart a frame mid-operation on reset, with the first visible tick after reset release producing frame_start.

Configuration
REQ-033 SHALL, when macro FB_SCANOUT_TESTPAT_EN is defined, add input test_sel (1 bit); with test_sel=1, pix SHALL be the checkerboard fb_x[3]^fb_y[3] replicated to DATAW bits, and data_out SHALL be ignored.
REQ-034 SHALL, without FB_SCANOUT_TESTPAT_EN, have no test_sel port, with pix always sourced from data_out.

Structure
REQ-035 SHALL place the VGA timing defaults and the H_TOTAL/V_TOTAL derivation in shared package video_pkg, also used by the drawing logic.
REQ-036 SHALL use one sub-module, vga_timing, holding the counters and the raw hsync/vsync/de generation.
REQ-037 SHALL keep the address generation and the alignment pipeline in fb_scanout.

Verification
REQ-038 SHALL cover: pix_ce every clk, one full frame -> 800 ticks/line, 525 lines; hsync low for exactly 96 ticks starting at tick 657 (hcnt 656 plus delay); vsync low for 2 lines.
REQ-039 SHALL cover: framebuffer model with data=addr[0], pix_ce every clk -> on line 0 addr_read sequence 0,0,1,1,2,2…; on line 2 addr_read starts at 320; pix matches the model one tick later.
REQ-040 SHALL cover: pix_ce every 2nd clk -> identical pixel/sync sequence to the previous scenario, with each output held for 2 clk.
REQ-041 SHALL cover: rst asserted at hcnt=300, vcnt=100 -> next clk de=0, hsync=vsync=1, addr_read=0; frame_start pulses once when the first visible pixel is output after release.
REQ-042 SHALL cover: full frame -> max addr_read=76799, de high for exactly 307200 ticks, frame_start once per frame.
REQ-043 SHALL cover, with FB_SCANOUT_TESTPAT_EN and test_sel=1: fb_x=8, fb_y=0 -> pix=1; fb_x=8, fb_y=8 -> pix=0.
